pll_rst_sequencer: RTL and testbench
====================================

// Module: pll_rst_sequencer
// PURPOSE
//  Supervises the core-clock PLL: drives its RST, waits for LOCKED with a timeout and bounded
//  retries, debounces lock, then releases N reset domains one by one at a fixed spacing. Sits beside
//  the clock generator, clocked by the free-running board clock. On lock loss or software request
//  it re-asserts all domain resets at once and restarts the sequence.
// PARAMETERS
//  N_STAGES      2      number of sequenced reset outputs (1..8)
//  RST_CYCLES    16     cycles o_pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT  100000 max cycles in WAIT_LOCK before an attempt fails (1 ms at 100 MHz)
//  STABLE_CYCLES 1024   cycles of continuous lock required before any reset is released
//  STAGE_GAP     16     cycles between consecutive stage releases (>=1)
//  MAX_RETRY     3      failed lock attempts allowed before FAIL
//  CNT_W         17     shared down-counter width; must hold the largest count parameter
// PORTS
//  i_clk        in  1         free-running board clock (not the PLL output)
//  i_rst_n      in  1         asynchronous active-low reset
//  i_locked     in  1         PLL LOCKED, asynchronous; 2-flop synchronised internally
//  i_sw_rst     in  1         single-cycle software reset-restart request
//  o_pll_rst    out 1         active-high reset to the PLL
//  o_rst_stage  out N_STAGES  active-high domain resets; bit 0 released first
//  o_ready      out 1         all stages released, lock held
//  o_fail       out 1         retries exhausted; sticky until i_rst_n
//  o_retry_cnt  out 3         failed attempts in the current sequence
// BEHAVIOUR
//  Reset (i_rst_n=0, async): state=PLL_RST, counter=RST_CYCLES-1, o_pll_rst=1, o_rst_stage=all 1,
//   o_ready=0, o_fail=0, o_retry_cnt=0, lock synchroniser=0. All outputs are registered.
//  lock_s = i_locked after 2 flops (2-3 cycle latency). All lock decisions use lock_s only.
//  FSM, one shared down-counter cnt, stage index idx:
//   PLL_RST : o_pll_rst=1; cnt hits 0 -> WAIT_LOCK, cnt=LOCK_TIMEOUT-1. Occupies exactly RST_CYCLES cycles.
//   WAIT_LOCK: o_pll_rst=0. lock_s=1 -> STABLE, cnt=STABLE_CYCLES-1.
//      cnt=0 with lock_s=0 -> retry_cnt+1; if new value > MAX_RETRY -> FAIL, else PLL_RST, cnt reload.
//   STABLE  : lock_s=0 -> WAIT_LOCK, cnt=LOCK_TIMEOUT-1 (glitch, not a retry).
//      cnt=0 with lock_s=1 -> RELEASE, idx=0, cnt=STAGE_GAP-1.
//   RELEASE : in the cycle after entry, clear o_rst_stage[0]; thereafter each STAGE_GAP cycles clear
//      next bit. After bit N_STAGES-1 clears -> RUN, o_ready=1 the same cycle as that bit clears.
//   RUN     : hold. retry_cnt cleared on entry.
//   FAIL    : o_fail=1, o_pll_rst=1, o_rst_stage all 1; exits only via i_rst_n.
//  Abort (lock_s falls in RELEASE/RUN, or i_sw_rst in any state except FAIL): next cycle all
//   o_rst_stage=1, o_ready=0, state=PLL_RST, cnt=RST_CYCLES-1; retry_cnt unchanged.
//   i_sw_rst in PLL_RST restarts its count. i_sw_rst ignored in FAIL.
//  Priority in one cycle: i_sw_rst > lock loss > counter expiry.
//  Stage resets never release out of order; any re-assertion is simultaneous on all bits.
//  o_rst_stage is in i_clk domain: each consumer resynchronises deassertion into its own clock.
//  Counter: saturating down-counter, never wraps; reload values are parameter-1 truncated to CNT_W.
// TESTING
//  (defaults, LOCK_TIMEOUT=200, STABLE_CYCLES=32 in bench)
//  T1 lock at cycle 40 held -> o_pll_rst high cycles 0-15; stage0 clears 40+2+32+1 (+-1 sync), stage1 16
//     later with o_ready=1.
//  T2 i_locked never rises -> 4 PLL_RST pulses of 16 cycles, o_retry_cnt 1,2,3, then o_fail=1 and
//     o_pll_rst stays 1; i_sw_rst ignored; i_rst_n pulse restores reset state.
//  T3 lock glitch low 3 cycles mid-STABLE -> STABLE restarts full 32 cycles; retry_cnt stays 0.
//  T4 in RUN drop i_locked -> within 3 cycles both stages =1, o_ready=0, o_pll_rst pulse 16 cycles.
//  T5 i_sw_rst between stage0 and stage1 release -> stage0 re-asserts next cycle, full resequence.
//  T6 i_rst_n asserted asynchronously mid-RELEASE (no clock edge) -> outputs reach reset values at once.

Source files
------------

// File: rtl/pll_rst_sequencer.sv
// PLL reset supervisor: pulses the PLL reset, waits for a debounced lock with bounded retries,
// then releases the domain resets in order. Lock loss or a software request restarts the sequence.
module pll_rst_sequencer #(
  parameter int unsigned N_STAGES      = 2,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 100000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_GAP     = 16,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 17
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_locked,
  input  logic                i_sw_rst,
  output logic                o_pll_rst,
  output logic [N_STAGES-1:0] o_rst_stage,
  output logic                o_ready,
  output logic                o_fail,
  output logic [2:0]          o_retry_cnt
);

  localparam int unsigned IdxW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CNT_W-1:0] RstLoad     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLoad = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLoad  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLoad     = CNT_W'(STAGE_GAP - 1);
  localparam logic [IdxW-1:0]  LastIdx     = IdxW'(N_STAGES - 1);

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRelease,
    StRun,
    StFail
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_dec;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [N_STAGES-1:0] stage_q, stage_d;
  logic [2:0]          retry_q, retry_d, retry_inc;
  logic                pll_rst_q, pll_rst_d;
  logic                ready_q, ready_d;
  logic                fail_q, fail_d;
  logic                lock_meta_q, lock_s_q;
  logic                abort;

  // i_locked comes straight from the PLL, asynchronous to i_clk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= i_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StPllRst;
      cnt_q     <= RstLoad;
      idx_q     <= '0;
      stage_q   <= '1;
      retry_q   <= 3'd0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stage_q   <= stage_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    stage_d   = stage_q;
    retry_d   = retry_q;
    ready_d   = ready_q;
    cnt_dec   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    retry_inc = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;

    // Software request outranks lock loss, which outranks any counter expiry.
    abort = (i_sw_rst && (state_q != StFail)) ||
            (!lock_s_q && ((state_q == StRelease) || (state_q == StRun)));

    if (abort) begin
      state_d = StPllRst;
      cnt_d   = RstLoad;
      stage_d = '1;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        StPllRst: begin
          if (cnt_q == '0) begin
            state_d = StWaitLock;
            cnt_d   = TimeoutLoad;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        StWaitLock: begin
          if (lock_s_q) begin
            state_d = StStable;
            cnt_d   = StableLoad;
          end else if (cnt_q == '0) begin
            retry_d = retry_inc;
            if (32'(retry_inc) > MAX_RETRY) begin
              state_d = StFail;
            end else begin
              state_d = StPllRst;
              cnt_d   = RstLoad;
            end
          end else begin
            cnt_d = cnt_dec;
          end
        end
        StStable: begin
          if (!lock_s_q) begin
            state_d = StWaitLock;
            cnt_d   = TimeoutLoad;
          end else if (cnt_q == '0) begin
            state_d = StRelease;
            idx_d   = '0;
            cnt_d   = GapLoad;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        StRelease: begin
          // Stage 0 goes on the first cycle; later stages wait a full gap each.
          if ((idx_q == '0) || (cnt_q == '0)) begin
            stage_d[idx_q] = 1'b0;
            if (idx_q == LastIdx) begin
              state_d = StRun;
              ready_d = 1'b1;
              retry_d = 3'd0;
            end else begin
              idx_d = idx_q + IdxW'(1);
              cnt_d = GapLoad;
            end
          end else begin
            cnt_d = cnt_dec;
          end
        end
        StRun:   ;
        StFail:  ;
        default: state_d = StFail;
      endcase
    end

    pll_rst_d = (state_d == StPllRst) || (state_d == StFail);
    fail_d    = (state_d == StFail);
    if (state_d == StFail) begin
      stage_d = '1;
      ready_d = 1'b0;
    end
  end

  assign o_pll_rst   = pll_rst_q;
  assign o_rst_stage = stage_q;
  assign o_ready     = ready_q;
  assign o_fail      = fail_q;
  assign o_retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Bench for pll_rst_sequencer: directed scenarios plus random lock/sw-reset traffic, all checked
// against a phase/elapsed-time reference model.
module tb_pll_rst_sequencer;

  localparam int unsigned NS = 2;
  localparam int unsigned RC = 16;
  localparam int unsigned LT = 200;
  localparam int unsigned SC = 32;
  localparam int unsigned SG = 16;
  localparam int unsigned MR = 3;
  localparam int unsigned CW = 17;
  localparam int VW = NS + 6;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_REL  = 3;
  localparam int PH_RUN  = 4;
  localparam int PH_FAIL = 5;

  localparam logic [VW-1:0] RST_VEC = {1'b0, 1'b0, 3'd0, 1'b1, {NS{1'b1}}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          locked;
  logic          sw_rst;
  logic          o_pll_rst;
  logic [NS-1:0] o_rst_stage;
  logic          o_ready;
  logic          o_fail;
  logic [2:0]    o_retry_cnt;
  logic [VW-1:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: current phase, edges spent in it, failed attempts, lock delay line.
  int m_phase;
  int m_t;
  int m_retry;
  bit m_s1;
  bit m_s2;

  pll_rst_sequencer #(
    .N_STAGES     (NS),
    .RST_CYCLES   (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .STAGE_GAP    (SG),
    .MAX_RETRY    (MR),
    .CNT_W        (CW)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_locked   (locked),
    .i_sw_rst   (sw_rst),
    .o_pll_rst  (o_pll_rst),
    .o_rst_stage(o_rst_stage),
    .o_ready    (o_ready),
    .o_fail     (o_fail),
    .o_retry_cnt(o_retry_cnt)
  );

  always #5 clk = ~clk;

  assign dut_vec = {o_fail, o_ready, o_retry_cnt, o_pll_rst, o_rst_stage};

  function automatic logic [VW-1:0] exp_vec();
    logic [NS-1:0] st;
    for (int i = 0; i < int'(NS); i++) begin
      if (m_phase == PH_RUN)      st[i] = 1'b0;
      else if (m_phase == PH_REL) st[i] = !(m_t >= 1 + i * int'(SG));
      else                        st[i] = 1'b1;
    end
    return {m_phase == PH_FAIL, m_phase == PH_RUN, 3'(m_retry),
            (m_phase == PH_RST) || (m_phase == PH_FAIL), st};
  endfunction

  task automatic model_reset();
    m_phase = PH_RST;
    m_t     = 0;
    m_retry = 0;
    m_s1    = 1'b0;
    m_s2    = 1'b0;
  endtask

  task automatic model_step();
    bit ls;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = locked;
    if (m_phase != PH_FAIL && sw_rst) begin
      m_phase = PH_RST;
      m_t     = 0;
    end else begin
      case (m_phase)
        PH_RST: begin
          if (m_t + 1 == int'(RC)) begin m_phase = PH_WAIT; m_t = 0; end
          else m_t++;
        end
        PH_WAIT: begin
          if (ls) begin
            m_phase = PH_STAB; m_t = 0;
          end else if (m_t + 1 == int'(LT)) begin
            m_retry++;
            m_phase = (m_retry > int'(MR)) ? PH_FAIL : PH_RST;
            m_t = 0;
          end else m_t++;
        end
        PH_STAB: begin
          if (!ls) begin m_phase = PH_WAIT; m_t = 0; end
          else if (m_t + 1 == int'(SC)) begin m_phase = PH_REL; m_t = 0; end
          else m_t++;
        end
        PH_REL: begin
          if (!ls) begin
            m_phase = PH_RST; m_t = 0;
          end else begin
            m_t++;
            if (m_t == 1 + (int'(NS) - 1) * int'(SG)) begin
              m_phase = PH_RUN; m_t = 0; m_retry = 0;
            end
          end
        end
        PH_RUN: begin
          if (!ls) begin m_phase = PH_RST; m_t = 0; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    locked = 1'b0;
    sw_rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if (dut_vec !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_held got=%b exp=%b", dut_vec, RST_VEC);
    end
    apply_reset();
    n_checks++;
    if (dut_vec !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_release got=%b exp=%b", dut_vec, RST_VEC);
    end
  endtask

  task automatic test_lock_release();
    int s0 = -1, s1 = -1, rdy = -1, pf = -1;
    apply_reset();
    for (int i = 0; i < 120; i++) begin
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL t1_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
      if (pf < 0 && !o_pll_rst) pf = cyc;
      if (s0 < 0 && !o_rst_stage[0]) s0 = cyc;
      if (s1 < 0 && !o_rst_stage[1]) s1 = cyc;
      if (rdy < 0 && o_ready) rdy = cyc;
      locked = (cyc >= 40);
      tick();
    end
    n_checks++;
    if (pf != int'(RC)) begin
      n_fail++;
      $display("FAIL t1_pll_rst_width got=%0d exp=%0d", pf, RC);
    end
    n_checks++;
    if (s0 < 40 + 2 + int'(SC) || s0 > 40 + 4 + int'(SC)) begin
      n_fail++;
      $display("FAIL t1_stage0_time got=%0d exp=%0d..%0d", s0, 40 + 2 + SC, 40 + 4 + SC);
    end
    n_checks++;
    if (s1 - s0 != int'(SG)) begin
      n_fail++;
      $display("FAIL t1_stage_gap got=%0d exp=%0d", s1 - s0, SG);
    end
    n_checks++;
    if (rdy != s1) begin
      n_fail++;
      $display("FAIL t1_ready_time got=%0d exp=%0d", rdy, s1);
    end
  endtask

  task automatic test_retry_fail();
    int pulses = 0, run = 0, bad_w = 0, rises = 0;
    int rise_retry[8];
    bit prev = 1'b0;
    logic [VW-1:0] held;
    for (int i = 0; i < 8; i++) rise_retry[i] = -1;
    apply_reset();
    for (int i = 0; i < 1200 && !o_fail; i++) begin
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL t2_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
      if (o_pll_rst && !prev) begin
        if (rises < 8) rise_retry[rises] = int'(o_retry_cnt);
        rises++;
        run = 1;
      end else if (o_pll_rst) begin
        run++;
      end else if (prev) begin
        pulses++;
        if (run != int'(RC)) bad_w++;
      end
      prev = o_pll_rst;
      tick();
    end
    n_checks++;
    if (!(o_fail === 1'b1 && o_pll_rst === 1'b1)) begin
      n_fail++;
      $display("FAIL t2_fail_reached fail=%b pll_rst=%b exp=1/1", o_fail, o_pll_rst);
    end
    n_checks++;
    if (pulses != int'(MR) + 1 || bad_w != 0) begin
      n_fail++;
      $display("FAIL t2_pulses got=%0d bad_width=%0d exp=%0d/0", pulses, bad_w, MR + 1);
    end
    n_checks++;
    if (rise_retry[1] != 1 || rise_retry[2] != 2 || rise_retry[3] != 3) begin
      n_fail++;
      $display("FAIL t2_retry_seq got=%0d,%0d,%0d exp=1,2,3",
               rise_retry[1], rise_retry[2], rise_retry[3]);
    end
    held = exp_vec();
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (dut_vec !== held || !o_fail) begin
        n_fail++;
        $display("FAIL t2_sw_rst_in_fail cyc=%0d got=%b exp=%b", cyc, dut_vec, held);
      end
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== RST_VEC) begin
      n_fail++;
      $display("FAIL t2_reset_exit got=%b exp=%b", dut_vec, RST_VEC);
    end
  endtask

  task automatic test_glitch();
    int l_cyc, g_cyc, r_cyc, s0 = -1, retry_bad = 0;
    bit rdy = 1'b0;
    apply_reset();
    l_cyc = int'($urandom_range(60, 20));
    g_cyc = l_cyc + 3 + int'($urandom_range(25, 5));
    r_cyc = g_cyc + 3;
    for (int i = 0; i < 200; i++) begin
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL t3_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
      if (o_retry_cnt != 3'd0) retry_bad++;
      if (s0 < 0 && !o_rst_stage[0]) s0 = cyc;
      if (o_ready) rdy = 1'b1;
      locked = (cyc >= l_cyc) && !(cyc >= g_cyc && cyc < r_cyc);
      tick();
    end
    n_checks++;
    if (s0 != r_cyc + int'(SC) + 4) begin
      n_fail++;
      $display("FAIL t3_stable_restart got=%0d exp=%0d", s0, r_cyc + int'(SC) + 4);
    end
    n_checks++;
    if (retry_bad != 0 || !rdy) begin
      n_fail++;
      $display("FAIL t3_no_retry retry_nonzero=%0d ready=%b exp=0/1", retry_bad, rdy);
    end
  endtask

  task automatic test_lock_loss_run();
    int d_cyc, ra = -1, pr = -1, pf = -1;
    bit rdy_at_d = 1'b0;
    apply_reset();
    d_cyc = 82 + int'($urandom_range(10, 0));
    for (int i = 0; i < d_cyc + 40; i++) begin
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL t4_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
      if (cyc == d_cyc) rdy_at_d = o_ready;
      if (cyc > d_cyc && ra < 0 && o_rst_stage == '1 && !o_ready) ra = cyc;
      if (cyc > d_cyc && pr < 0 && o_pll_rst) pr = cyc;
      if (pr >= 0 && pf < 0 && !o_pll_rst) pf = cyc;
      locked = (cyc >= 20) && (cyc < d_cyc);
      tick();
    end
    n_checks++;
    if (!rdy_at_d) begin
      n_fail++;
      $display("FAIL t4_ready_before_loss got=%b exp=1", rdy_at_d);
    end
    n_checks++;
    if (ra < 0 || ra - d_cyc > 3) begin
      n_fail++;
      $display("FAIL t4_reassert_latency got=%0d exp<=3", ra - d_cyc);
    end
    n_checks++;
    if (pf - pr != int'(RC)) begin
      n_fail++;
      $display("FAIL t4_pll_pulse got=%0d exp=%0d", pf - pr, RC);
    end
  endtask

  task automatic test_sw_rst_release();
    int s_cyc, s0b = -1;
    apply_reset();
    s_cyc = 56 + int'($urandom_range(10, 0));
    for (int i = 0; i < s_cyc + 80; i++) begin
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL t5_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
      if (cyc == s_cyc + 1) begin
        n_checks++;
        if (!(o_rst_stage == '1 && o_pll_rst && !o_ready)) begin
          n_fail++;
          $display("FAIL t5_sw_abort stage=%b pll=%b ready=%b exp=%b/1/0",
                   o_rst_stage, o_pll_rst, o_ready, {NS{1'b1}});
        end
      end
      if (cyc > s_cyc + 1 && s0b < 0 && !o_rst_stage[0]) s0b = cyc;
      locked = (cyc >= 20);
      sw_rst = (cyc == s_cyc);
      tick();
    end
    sw_rst = 1'b0;
    n_checks++;
    if (s0b != s_cyc + int'(RC) + int'(SC) + 3) begin
      n_fail++;
      $display("FAIL t5_resequence got=%0d exp=%0d", s0b, s_cyc + int'(RC + SC) + 3);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL t6_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
      locked = (cyc >= 20);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== RST_VEC) begin
      n_fail++;
      $display("FAIL t6_async_reset got=%b exp=%b", dut_vec, RST_VEC);
    end
  endtask

  task automatic test_random();
    int seg = 0, dwell = 0;
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
      if (m_phase == PH_FAIL) dwell++;
      if (dwell > 10) begin
        apply_reset();
        dwell = 0;
        seg   = 0;
      end
      if (seg == 0) begin
        locked = ~locked;
        if (locked) seg = int'($urandom_range(400, 30));
        else if ($urandom_range(9, 0) == 0) seg = int'($urandom_range(260, 150));
        else seg = int'($urandom_range(8, 1));
      end
      seg--;
      sw_rst = ($urandom_range(299, 0) == 0);
      tick();
    end
    sw_rst = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    locked = 1'b0;
    sw_rst = 1'b0;
    model_reset();
    test_reset();
    test_lock_release();
    test_retry_fail();
    test_glitch();
    test_lock_loss_run();
    test_sw_rst_release();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
